// File: rtl/ccff_bitstream_loader_if.sv
// Word stream from the PMU bitstream source into the CCFF loader.
// The source drives valid/data and the loader answers with ready.
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 32
);
    logic              s_valid;
    logic [WORD_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words MSB-first into a CCFF chain head, checks the looped-back
// marker bit on ccff_tail and releases IO isolation only after a clean load.
module ccff_bitstream_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 64
) (
    input  logic                          prog_clk,
    input  logic                          pReset_N,
    input  logic                          start,
    ccff_bitstream_loader_if.slave        s,
    output logic                          ccff_head,
    output logic                          ccff_shift_en,
    input  logic                          ccff_tail,
    output logic                          IO_ISOL_N,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam int K_W   = $clog2(CHAIN_LEN + 2);
    localparam int IDX_W = $clog2(WORD_W + 1);
    localparam logic [K_W-1:0] K_CHECK = K_W'(CHAIN_LEN);
    localparam logic [K_W-1:0] K_LAST  = K_W'(CHAIN_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  sreg_q, sreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [K_W-1:0]     k_q, k_d;
    logic               sample_q, sample_d;
    logic               s_ready_q, s_ready_d;
    logic               head_q, head_d;
    logic               shift_en_q, shift_en_d;
    logic               isol_n_q, isol_n_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic [K_W-1:0]     k_inc;
    logic               tail_bad;

    assign k_inc = k_q + K_W'(1);

    // sample_q marks the cycle after a shift edge; tail must show 0 until the marker arrives at k = N.
    assign tail_bad = sample_q && (k_q <= K_CHECK) && (ccff_tail != (k_q == K_CHECK));

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        idx_d      = idx_q;
        k_d        = k_q;
        sample_d   = shift_en_q;
        s_ready_d  = s_ready_q;
        head_d     = head_q;
        shift_en_d = shift_en_q;
        isol_n_d   = isol_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q | tail_bad;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d   = S_LOAD;
                    k_d       = '0;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    isol_n_d  = 1'b0;
                    s_ready_d = 1'b1;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_LOAD: begin
                if (s.s_valid) begin
                    sreg_d     = s.s_data;
                    idx_d      = IDX_W'(WORD_W);
                    head_d     = s.s_data[WORD_W-1];
                    shift_en_d = 1'b1;
                    s_ready_d  = 1'b0;
                    state_d    = S_SHIFT;
                end
            end

            S_SHIFT: begin
                k_d    = k_inc;
                idx_d  = idx_q - IDX_W'(1);
                sreg_d = sreg_q << 1;
                if (k_inc == K_LAST) begin
                    shift_en_d = 1'b0;
                    head_d     = 1'b0;
                    busy_d     = 1'b0;
                    if (error_d) begin
                        state_d = S_ERR;
                    end else begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        isol_n_d = 1'b1;
                    end
                end else if (idx_q == IDX_W'(1)) begin
                    state_d    = S_LOAD;
                    shift_en_d = 1'b0;
                    head_d     = 1'b0;
                    s_ready_d  = 1'b1;
                end else begin
                    head_d = sreg_d[WORD_W-1];
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_N) begin
        if (!pReset_N) begin
            state_q    <= S_IDLE;
            sreg_q     <= '0;
            idx_q      <= '0;
            k_q        <= '0;
            sample_q   <= 1'b0;
            s_ready_q  <= 1'b0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            isol_n_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            idx_q      <= idx_d;
            k_q        <= k_d;
            sample_q   <= sample_d;
            s_ready_q  <= s_ready_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
            isol_n_q   <= isol_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign s.s_ready     = s_ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign IO_ISOL_N     = isol_n_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a CCFF chain model on the head/tail pins, a vector table
// for the nominal corner cases, hand-written reset/ignored-input sequences and random loads.
module tb_ccff_bitstream_loader;

    localparam int W     = 8;
    localparam int N     = 10;
    localparam int T     = N + 1;
    localparam int WORDS = (T + W - 1) / W;
    localparam int PAD   = WORDS * W - T;

    typedef struct {
        logic [N-1:0] cfg;
        logic [N-1:0] pre;
        bit           broken;
        int           stall;
        bit           exp_done;
        bit           exp_err;
        bit           exp_isol;
        logic [N-1:0] exp_chain;
    } vec_t;

    logic prog_clk;
    logic pReset_N;
    logic start;
    logic ccff_head;
    logic ccff_shift_en;
    logic ccff_tail;
    logic IO_ISOL_N;
    logic busy;
    logic done;
    logic error;

    ccff_bitstream_loader_if #(.WORD_W(W)) sif ();

    ccff_bitstream_loader #(
        .WORD_W    (W),
        .CHAIN_LEN (N)
    ) dut (
        .prog_clk      (prog_clk),
        .pReset_N      (pReset_N),
        .start         (start),
        .s             (sif),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .IO_ISOL_N     (IO_ISOL_N),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Chain model: cell 0 is fed by ccff_head, cell N-1 drives ccff_tail.
    logic [N-1:0] chain;
    logic [N-1:0] preload_val;
    logic         preload_req;
    logic         broken;

    always @(posedge prog_clk) begin
        if (preload_req)
            chain <= preload_val;
        else if (ccff_shift_en)
            chain <= {chain[N-2:0], ccff_head};
    end

    assign ccff_tail = broken ? 1'b0 : chain[N-1];

    int shift_cnt = 0;
    int hs_cnt    = 0;
    int done_cnt  = 0;

    always @(posedge prog_clk) begin
        if (ccff_shift_en === 1'b1) shift_cnt <= shift_cnt + 1;
        if (sif.s_valid === 1'b1 && sif.s_ready === 1'b1) hs_cnt <= hs_cnt + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[5];
    vec_t rv;
    bit   rerr;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Reference: push the stream through an abstract chain and apply the tail rule per completed shift.
    task automatic refModel(input logic [N-1:0] cfg, input logic [N-1:0] pre, input bit brk,
                            output bit err, output logic [N-1:0] fin);
        logic         q[$];
        logic [T-1:0] stream;
        logic         tail;
        stream = {1'b1, cfg};
        err    = 1'b0;
        for (int c = N - 1; c >= 0; c--) q.push_back(pre[c]);
        for (int k = 1; k <= T; k++) begin
            void'(q.pop_front());
            q.push_back(stream[T-k]);
            tail = brk ? 1'b0 : q[0];
            if (k <= N && tail != (k == N)) err = 1'b1;
        end
        for (int c = 0; c < N; c++) fin[c] = q[N-1-c];
    endtask

    task automatic preloadChain(input logic [N-1:0] val, input bit brk);
        @(negedge prog_clk);
        preload_val = val;
        preload_req = 1'b1;
        broken      = brk;
        @(negedge prog_clk);
        preload_req = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input bit early, input bit noisy);
        logic [T-1:0]       stream;
        logic [WORDS*W-1:0] padded;
        logic [W-1:0]       word;
        int                 s0, h0, d0, wait_cnt, stall_bad;
        preloadChain(v.pre, v.broken);
        stream = {1'b1, v.cfg};
        padded = '0;
        padded[WORDS*W-1 -: T] = stream;
        if (early) for (int i = 0; i < PAD; i++) padded[i] = 1'($urandom_range(0, 1));
        s0 = shift_cnt; h0 = hs_cnt; d0 = done_cnt; stall_bad = 0;

        @(negedge prog_clk); start = 1'b1;
        @(negedge prog_clk); start = 1'b0;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_ready", sif.s_ready, 1);
        checkOutput("start_err_clr", error, 0);
        checkOutput("start_isol", IO_ISOL_N, 0);

        for (int w = 0; w < WORDS; w++) begin
            word = padded[WORDS*W-1-w*W -: W];
            wait_cnt = 0;
            while (sif.s_ready !== 1'b1 && wait_cnt < 50) begin
                start = noisy && busy && ($urandom_range(0, 1) == 1);
                @(negedge prog_clk);
                wait_cnt++;
            end
            start = 1'b0;
            checkOutput("ready_seen", sif.s_ready, 1);
            if (!early) begin
                for (int i = 0; i < v.stall; i++) begin
                    sif.s_valid = 1'b0;
                    @(negedge prog_clk);
                    if (ccff_shift_en !== 1'b0 || sif.s_ready !== 1'b1) stall_bad++;
                end
            end
            sif.s_valid = 1'b1;
            sif.s_data  = word;
            @(negedge prog_clk);
            checkOutput("first_shift_en", ccff_shift_en, 1);
            checkOutput("ready_drop", sif.s_ready, 0);
            if (early && w < WORDS - 1)
                sif.s_data = padded[WORDS*W-1-(w+1)*W -: W];
            else if (early || noisy)
                sif.s_data = W'($urandom);
            else
                sif.s_valid = 1'b0;
        end

        wait_cnt = 0;
        while (busy === 1'b1 && wait_cnt < 100) begin
            start = noisy && ($urandom_range(0, 1) == 1);
            @(negedge prog_clk);
            wait_cnt++;
        end
        start = 1'b0;
        checkOutput("end_busy", busy, 0);
        checkOutput("end_done", done, v.exp_done);
        checkOutput("end_isol", IO_ISOL_N, v.exp_isol);
        checkOutput("end_error", error, v.exp_err);
        checkOutput("shift_count", shift_cnt - s0, T);
        checkOutput("handshakes", hs_cnt - h0, WORDS);
        checkOutput("stall_no_shift", stall_bad, 0);

        @(negedge prog_clk);
        checkOutput("done_pulse_len", done, 0);
        checkOutput("done_count", done_cnt - d0, v.exp_done);
        checkOutput("isol_hold", IO_ISOL_N, v.exp_isol);
        checkOutput("err_sticky", error, v.exp_err);
        checkOutput("chain", chain, v.exp_chain);
        @(negedge prog_clk);
        sif.s_valid = 1'b0;
        checkOutput("idle_ready", sif.s_ready, 0);
        checkOutput("idle_handshakes", hs_cnt - h0, WORDS);
    endtask

    task automatic midLoadReset();
        int s0, d0;
        preloadChain('0, 1'b0);
        s0 = shift_cnt; d0 = done_cnt;
        @(negedge prog_clk); start = 1'b1;
        @(negedge prog_clk); start = 1'b0;
        sif.s_valid = 1'b1;
        sif.s_data  = 8'hD5;
        @(negedge prog_clk);
        sif.s_valid = 1'b0;
        repeat (4) @(negedge prog_clk);
        checkOutput("pre_rst_shifts", shift_cnt - s0, 4);
        #2 pReset_N = 1'b0;
        #1;
        checkOutput("mrst_ready", sif.s_ready, 0);
        checkOutput("mrst_head", ccff_head, 0);
        checkOutput("mrst_shift_en", ccff_shift_en, 0);
        checkOutput("mrst_isol", IO_ISOL_N, 0);
        checkOutput("mrst_busy", busy, 0);
        checkOutput("mrst_done", done, 0);
        checkOutput("mrst_error", error, 0);
        @(negedge prog_clk);
        pReset_N = 1'b1;
        repeat (3) @(negedge prog_clk);
        checkOutput("post_rst_ready", sif.s_ready, 0);
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_shifts", shift_cnt - s0, 4);
        checkOutput("post_rst_no_done", done_cnt - d0, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        start       = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        preload_req = 1'b0;
        preload_val = '0;
        broken      = 1'b0;
        pReset_N    = 1'b1;
        #3 pReset_N = 1'b0;
        repeat (2) @(negedge prog_clk);
        checkOutput("rst_ready", sif.s_ready, 0);
        checkOutput("rst_head", ccff_head, 0);
        checkOutput("rst_shift_en", ccff_shift_en, 0);
        checkOutput("rst_isol", IO_ISOL_N, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        pReset_N = 1'b1;

        vecs[0] = '{cfg: 10'h2AA, pre: 10'h000, broken: 1'b0, stall: 0,
                    exp_done: 1'b1, exp_err: 1'b0, exp_isol: 1'b1, exp_chain: 10'h2AA};
        vecs[1] = '{cfg: 10'h2AA, pre: 10'h000, broken: 1'b0, stall: 5,
                    exp_done: 1'b1, exp_err: 1'b0, exp_isol: 1'b1, exp_chain: 10'h2AA};
        vecs[2] = '{cfg: 10'h2AA, pre: 10'h004, broken: 1'b0, stall: 0,
                    exp_done: 1'b0, exp_err: 1'b1, exp_isol: 1'b0, exp_chain: 10'h2AA};
        vecs[3] = '{cfg: 10'h155, pre: 10'h000, broken: 1'b1, stall: 0,
                    exp_done: 1'b0, exp_err: 1'b1, exp_isol: 1'b0, exp_chain: 10'h155};
        vecs[4] = '{cfg: 10'h155, pre: 10'h000, broken: 1'b0, stall: 1,
                    exp_done: 1'b1, exp_err: 1'b0, exp_isol: 1'b1, exp_chain: 10'h155};

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], 1'b0, 1'b0);

        applyStimulus(vecs[0], 1'b1, 1'b1);

        midLoadReset();
        applyStimulus(vecs[0], 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            rv.cfg    = N'($urandom);
            rv.pre    = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            rv.broken = ($urandom_range(0, 4) == 0);
            rv.stall  = $urandom_range(0, 3);
            refModel(rv.cfg, rv.pre, rv.broken, rerr, rv.exp_chain);
            rv.exp_err  = rerr;
            rv.exp_done = !rerr;
            rv.exp_isol = !rerr;
            applyStimulus(rv, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
